mem_bus_port: RTL
=================

Name: mem_bus_port

Overview:
Receiving end of the 16-bit datapath bus. Latches bus values into MAR and MDR on load strobes. Runs memory read/write accesses through a fixed-wait-state SRAM-style strobe interface, with one access in flight at a time. MDR is the source the bus driver gates onto the bus under GateMDR, which closes the loop between bus driver and bus consumer.

Parameters:
WAIT_STATES, 2, extra cycles beyond one that memory strobes stay asserted; legal range 1..15
DATA_W, 16, bus, MDR and memory data width
ADDR_W, 16, MAR and memory address width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
bus_in  in  DATA_W  current bus value
LD_MAR  in  1  load MAR from bus_in
LD_MDR  in  1  load MDR from bus_in
start_rd  in  1  request memory read at MAR into MDR
start_wr  in  1  request memory write of MDR to MAR
mem_data_in  in  DATA_W  read data from memory
MAR  out  ADDR_W  address register
MDR  out  DATA_W  data register (feeds bus driver MDR_data)
mem_addr  out  ADDR_W  equals MAR at all times
mem_data_out  out  DATA_W  equals MDR at all times
mem_CE_n  out  1  chip enable, active-low
mem_OE_n  out  1  output enable, active-low
mem_WE_n  out  1  write enable, active-low
busy  out  1  access in progress
Ready  out  1  one-cycle access-complete pulse

Behaviour:
- Reset (async, Reset=0) forces, without waiting for a clock edge:
  - MAR=0, MDR=0
  - mem_CE_n=mem_OE_n=mem_WE_n=1
  - busy=0, Ready=0
  - state IDLE, wait counter 0
- Reset mid-access aborts the access immediately. No MDR update occurs.
- State machine: IDLE, RD_ACT, WR_ACT, DONE.
- IDLE:
  - LD_MAR sets MAR<=bus_in; LD_MDR sets MDR<=bus_in. Both may occur in the same cycle.
  - start_rd moves to RD_ACT; else start_wr moves to WR_ACT. Read wins if both are asserted.
  - A load and a start in the same cycle are legal. The access uses the newly loaded MAR/MDR because strobes begin the following cycle.
- RD_ACT:
  - mem_CE_n=0, mem_OE_n=0, mem_WE_n=1.
  - Lasts exactly WAIT_STATES+1 cycles.
  - On the clock edge ending the last cycle, MDR<=mem_data_in; go to DONE.
- WR_ACT:
  - mem_CE_n=0, mem_WE_n=0, mem_OE_n=1.
  - Lasts exactly WAIT_STATES+1 cycles; then go to DONE. MDR unchanged.
- DONE: all strobes 1, Ready=1 for one cycle, then IDLE.
- busy=1 in RD_ACT, WR_ACT and DONE; otherwise 0.
- While busy, LD_MAR, LD_MDR, start_rd and start_wr are ignored, so MAR/MDR stay stable for the whole access. Commands issued in DONE are dropped.
- Latency: start sampled at edge ending cycle 0 → strobes active in cycles 1..WAIT_STATES+1 → Ready in cycle WAIT_STATES+2 → next command accepted in cycle WAIT_STATES+3.
- All strobe outputs and Ready are registered and glitch-free.
- Wait counter width is $clog2(WAIT_STATES+1). It loads WAIT_STATES on entry to RD_ACT/WR_ACT and decrements to 0. The last active cycle is the one where the count is 0.

Decomposition:
- Package mem_port_pkg:
  - enum typedef mem_state_t {IDLE, RD_ACT, WR_ACT, DONE}
  - constants STROBE_ON=1'b0, STROBE_OFF=1'b1
- One sub-module, mem_wait_counter:
  - inputs: load pulse, load value WAIT_STATES
  - outputs: count, terminal flag (count==0)
  - async active-low reset
- FSM and registers stay in mem_bus_port.

Test Plan:
1. Reset=0 mid-run → same cycle: MAR=0x0000, MDR=0x0000, CE_n/OE_n/WE_n=1, busy=0, Ready=0.
2. Read, WAIT_STATES=2:
   - Stimulus: LD_MAR with bus_in=0x3000, next cycle start_rd; mem_data_in=0xBEEF.
   - Required: CE_n/OE_n low for cycles 1–3 with mem_addr=0x3000, WE_n=1; Ready high in cycle 4 only; MDR=0xBEEF from cycle 4.
3. Write with load in the same cycle:
   - Stimulus: LD_MAR with bus_in=0x1234; next cycle LD_MDR with bus_in=0xA5A5 plus start_wr in that same cycle.
   - Required: WE_n low exactly 3 cycles, mem_addr=0x1234, mem_data_out=0xA5A5, OE_n=1; Ready one cycle; MDR still 0xA5A5.
4. Loads during a read:
   - Stimulus: during the test-2 read, LD_MAR with bus_in=0xFFFF and LD_MDR with bus_in=0x0001.
   - Required: mem_addr stays 0x3000; final MDR=0xBEEF; MAR stays 0x3000.
5. start_rd and start_wr asserted together in IDLE → read performed (OE_n low, WE_n stays 1 throughout); a start_wr issued during DONE is dropped.
6. Reset mid-write:
   - Stimulus: Reset=0 in cycle 2 of a write.
   - Required: WE_n=1 and CE_n=1 immediately, no Ready pulse. After release, a read of 0x0000 with mem_data_in=0x0042 completes normally with MDR=0x0042.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory bus port: access state encoding
// and active-low strobe levels.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACT = 2'd1,
    WR_ACT = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loads WAIT_STATES on a load pulse and counts down
// to zero while enabled; terminal marks the final active cycle.
module mem_wait_counter #(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = $clog2(WAIT_STATES + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_STATES);

  // Count register: load wins over decrement, and the count never wraps below zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != {CNT_W{1'b0}})) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_bus_port.sv
// Bus-side MAR/MDR holder and single-outstanding SRAM access sequencer with
// a fixed number of wait states; all strobes, busy and Ready are registered.
module mem_bus_port
  import mem_port_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_CE_n,
  output logic              mem_OE_n,
  output logic              mem_WE_n,
  output logic              busy,
  output logic              Ready
);

  localparam int CNT_W = $clog2(WAIT_STATES + 1);

  mem_state_t       state;
  logic             wait_load;
  logic             wait_dec;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;
  logic [ADDR_W-1:0] bus_addr;

  // MAR is loaded straight from the bus; the bus is DATA_W wide.
  assign bus_addr = ADDR_W'(bus_in);

  // The counter is armed by the same edge that leaves IDLE, so the strobes
  // and the first wait cycle line up.
  assign wait_load = (state == IDLE) && (start_rd || start_wr);
  assign wait_dec  = ((state == RD_ACT) || (state == WR_ACT)) && (wait_cnt != {CNT_W{1'b0}});

  mem_wait_counter #(
    .WAIT_STATES (WAIT_STATES),
    .CNT_W       (CNT_W)
  ) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (wait_load),
    .dec      (wait_dec),
    .count    (wait_cnt),
    .terminal (wait_last)
  );

  assign mem_addr     = MAR;
  assign mem_data_out = MDR;

  // Access FSM with registered strobes; loads and starts are only honoured in IDLE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      MAR      <= {ADDR_W{1'b0}};
      MDR      <= {DATA_W{1'b0}};
      mem_CE_n <= STROBE_OFF;
      mem_OE_n <= STROBE_OFF;
      mem_WE_n <= STROBE_OFF;
      busy     <= 1'b0;
      Ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Ready <= 1'b0;
          if (LD_MAR) begin
            MAR <= bus_addr;
          end
          if (LD_MDR) begin
            MDR <= bus_in;
          end
          if (start_rd) begin
            state    <= RD_ACT;
            mem_CE_n <= STROBE_ON;
            mem_OE_n <= STROBE_ON;
            mem_WE_n <= STROBE_OFF;
            busy     <= 1'b1;
          end else if (start_wr) begin
            state    <= WR_ACT;
            mem_CE_n <= STROBE_ON;
            mem_OE_n <= STROBE_OFF;
            mem_WE_n <= STROBE_ON;
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            mem_CE_n <= STROBE_OFF;
            mem_OE_n <= STROBE_OFF;
            mem_WE_n <= STROBE_OFF;
            busy     <= 1'b0;
          end
        end
        RD_ACT: begin
          if (wait_last) begin
            MDR      <= mem_data_in;
            state    <= DONE;
            mem_CE_n <= STROBE_OFF;
            mem_OE_n <= STROBE_OFF;
            Ready    <= 1'b1;
          end else begin
            state <= RD_ACT;
          end
        end
        WR_ACT: begin
          if (wait_last) begin
            state    <= DONE;
            mem_CE_n <= STROBE_OFF;
            mem_WE_n <= STROBE_OFF;
            Ready    <= 1'b1;
          end else begin
            state <= WR_ACT;
          end
        end
        DONE: begin
          state <= IDLE;
          Ready <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_CE_n <= STROBE_OFF;
          mem_OE_n <= STROBE_OFF;
          mem_WE_n <= STROBE_OFF;
          busy     <= 1'b0;
          Ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
